// File: rtl/dma64_load_stage.sv
// DMA read load stage: splits a depth-word load into bursts of at most
// BURST_LEN 64-bit beats and forwards the returned words through a one-word
// output register to the compute core, then signals completion.
module dma64_load_stage #(
  parameter int unsigned BURST_LEN = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] conf_info_depth,
  input  logic        conf_done,
  output logic        dma_read_ctrl_valid,
  input  logic        dma_read_ctrl_ready,
  output logic [31:0] dma_read_ctrl_data_index,
  output logic [31:0] dma_read_ctrl_data_length,
  output logic [2:0]  dma_read_ctrl_data_size,
  input  logic        dma_read_chnl_valid,
  output logic        dma_read_chnl_ready,
  input  logic [63:0] dma_read_chnl_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_last,
  output logic        acc_done
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StData,
    StFlush,
    StDone
  } state_t;

  state_t      state;
  logic [31:0] index;
  logic [31:0] remaining;
  logic [31:0] beat_cnt;
  logic [31:0] burst_len;
  logic [31:0] req_len;
  logic        chnl_beat;
  logic        out_hs;

  assign burst_len = 32'(BURST_LEN);
  assign req_len   = (remaining < burst_len) ? remaining : burst_len;
  assign chnl_beat = dma_read_chnl_valid & dma_read_chnl_ready;
  assign out_hs    = out_valid & out_ready;

  // Request and stream-ready outputs decoded from state; registers are stable in StReq,
  // so the request fields cannot change while a request waits for ready.
  always_comb begin
    dma_read_ctrl_valid       = (state == StReq);
    dma_read_ctrl_data_index  = (state == StReq) ? index : 32'd0;
    dma_read_ctrl_data_length = (state == StReq) ? req_len : 32'd0;
    dma_read_ctrl_data_size   = (state == StReq) ? 3'b011 : 3'b000;
    dma_read_chnl_ready       = (state == StData) && (!out_valid || out_ready);
  end

  // Control FSM, burst bookkeeping and the registered output word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= StIdle;
      index     <= 32'd0;
      remaining <= 32'd0;
      beat_cnt  <= 32'd0;
      out_valid <= 1'b0;
      out_data  <= 64'd0;
      out_last  <= 1'b0;
      acc_done  <= 1'b0;
    end else begin
      acc_done <= 1'b0;

      // A new beat replaces the held word even when it is consumed this cycle.
      if (chnl_beat) begin
        out_data  <= dma_read_chnl_data;
        out_valid <= 1'b1;
        out_last  <= (remaining == 32'd1);
      end else if (out_hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      case (state)
        StIdle: begin
          if (conf_done) begin
            remaining <= conf_info_depth;
            index     <= 32'd0;
            if (conf_info_depth != 32'd0) begin
              state <= StReq;
            end else begin
              state    <= StDone;
              acc_done <= 1'b1;
            end
          end
        end
        StReq: begin
          if (dma_read_ctrl_ready) begin
            beat_cnt <= req_len;
            index    <= index + req_len;
            state    <= StData;
          end
        end
        StData: begin
          if (chnl_beat) begin
            beat_cnt  <= beat_cnt - 32'd1;
            remaining <= remaining - 32'd1;
            if (beat_cnt == 32'd1) begin
              state <= (remaining != 32'd1) ? StReq : StFlush;
            end
          end
        end
        StFlush: begin
          // Leave once the last word is gone or is being taken this cycle.
          if (!out_valid || out_ready) begin
            state    <= StDone;
            acc_done <= 1'b1;
          end
        end
        StDone: begin
          if (!conf_done) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dma64_load_stage.sv
// Self-checking bench for dma64_load_stage: a randomized DMA memory responder
// plus a reference model that derives the expected request list and word
// stream directly from the load depth and burst size.
module tb_dma64_load_stage;

  localparam int unsigned BL = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] conf_info_depth;
  logic        conf_done;
  logic        ctrl_valid;
  logic        ctrl_ready;
  logic [31:0] ctrl_index;
  logic [31:0] ctrl_length;
  logic [2:0]  ctrl_size;
  logic        chnl_valid;
  logic        chnl_ready;
  logic [63:0] chnl_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;
  logic        acc_done;

  dma64_load_stage #(.BURST_LEN(BL)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .conf_info_depth           (conf_info_depth),
    .conf_done                 (conf_done),
    .dma_read_ctrl_valid       (ctrl_valid),
    .dma_read_ctrl_ready       (ctrl_ready),
    .dma_read_ctrl_data_index  (ctrl_index),
    .dma_read_ctrl_data_length (ctrl_length),
    .dma_read_ctrl_data_size   (ctrl_size),
    .dma_read_chnl_valid       (chnl_valid),
    .dma_read_chnl_ready       (chnl_ready),
    .dma_read_chnl_data        (chnl_data),
    .out_valid                 (out_valid),
    .out_ready                 (out_ready),
    .out_data                  (out_data),
    .out_last                  (out_last),
    .acc_done                  (acc_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Observation logs filled by the monitor
  logic [31:0] req_idx_q[$];
  logic [31:0] req_len_q[$];
  logic [63:0] out_w_q[$];
  logic        out_l_q[$];
  int acc_cnt, beats, inv_err, hold_err, stab_err, ctrl_valid_cycles;

  // Responder knobs
  int out_pct = 100;
  int chnl_pct = 100;
  int ctrl_stall = 0;
  logic [31:0] salt = 32'd0;

  // Responder-private state
  logic [31:0] pending[$];
  bit c_hs, ch_hs, o_hs;
  bit hold_pend, ctrl_pend;
  logic [63:0] hold_data;
  logic hold_last;
  logic [31:0] pend_idx, pend_len;

  function automatic logic [63:0] word_of(input logic [31:0] a);
    return {a ^ salt, ~a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    req_idx_q.delete(); req_len_q.delete(); out_w_q.delete(); out_l_q.delete();
    acc_cnt = 0; beats = 0; inv_err = 0; hold_err = 0; stab_err = 0;
    ctrl_valid_cycles = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl_valid"}, ctrl_valid, 0);
    chk({tag, "_ctrl_index"}, ctrl_index, 0);
    chk({tag, "_ctrl_length"}, ctrl_length, 0);
    chk({tag, "_ctrl_size"}, ctrl_size, 0);
    chk({tag, "_chnl_ready"}, chnl_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_acc_done"}, acc_done, 0);
  endtask

  // Monitor samples at negedge; responder drives just after posedge.
  initial begin
    ctrl_ready = 1'b0; chnl_valid = 1'b0; chnl_data = 64'd0; out_ready = 1'b0;
    hold_pend = 0; ctrl_pend = 0; hold_data = 0; hold_last = 0; pend_idx = 0; pend_len = 0;
    forever begin
      @(negedge clk);
      c_hs  = rst && ctrl_valid && ctrl_ready;
      ch_hs = rst && chnl_valid && chnl_ready;
      o_hs  = rst && out_valid && out_ready;
      if (rst) begin
        if (ctrl_valid) ctrl_valid_cycles++;
        if (c_hs) begin
          req_idx_q.push_back(ctrl_index);
          req_len_q.push_back(ctrl_length);
        end
        if (o_hs) begin
          out_w_q.push_back(out_data);
          out_l_q.push_back(out_last);
        end
        if (ch_hs) beats++;
        if (acc_done) acc_cnt++;
        if (out_valid && !out_ready && chnl_ready) inv_err++;
        if (hold_pend && (!out_valid || out_data !== hold_data || out_last !== hold_last))
          hold_err++;
        if (ctrl_pend && (!ctrl_valid || ctrl_index !== pend_idx || ctrl_length !== pend_len))
          stab_err++;
        hold_pend = out_valid && !out_ready;
        hold_data = out_data;
        hold_last = out_last;
        ctrl_pend = ctrl_valid && !ctrl_ready;
        pend_idx  = ctrl_index;
        pend_len  = ctrl_length;
      end else begin
        hold_pend = 0;
        ctrl_pend = 0;
      end
      @(posedge clk);
      #1;
      if (!rst) begin
        pending.delete();
        chnl_valid = 1'b0;
        ctrl_ready = 1'b0;
        out_ready  = 1'b0;
      end else begin
        if (c_hs) for (int i = 0; i < int'(pend_len); i++) pending.push_back(pend_idx + i);
        if (ch_hs) void'(pending.pop_front());
        if (!(chnl_valid && !ch_hs))
          chnl_valid = (pending.size() > 0) && ($urandom_range(99) < chnl_pct);
        if (chnl_valid) chnl_data = word_of(pending[0]);
        if (ctrl_stall > 0 && ctrl_valid) begin
          ctrl_ready = 1'b0;
          ctrl_stall--;
        end else begin
          ctrl_ready = 1'b1;
        end
        out_ready = ($urandom_range(99) < out_pct);
      end
    end
  end

  // Start a load, wait for completion, optionally keep conf_done high, then drop it.
  task automatic run_load(input logic [31:0] depth, input int hold);
    clear_logs();
    salt = $urandom;
    conf_info_depth = depth;
    conf_done = 1'b1;
    @(posedge clk); #2;
    conf_info_depth = $urandom;  // must be ignored outside idle
    for (int i = 0; i < 3000 && acc_cnt == 0; i++) begin
      @(posedge clk); #2;
    end
    chk("acc_seen", acc_cnt != 0, 1);
    repeat (hold) @(posedge clk);
    #2;
    conf_done = 1'b0;
    repeat (3) @(posedge clk);
    #2;
  endtask

  // Reference: bursts of min(left, BL) from index 0, words in address order, last on final.
  task automatic check_load(input string tag, input logic [31:0] depth);
    logic [31:0] off, len;
    int n, m;
    off = 0; n = 0;
    while (off < depth) begin
      len = ((depth - off) < BL) ? (depth - off) : BL;
      if (n < req_idx_q.size()) begin
        chk({tag, "_req_index"}, req_idx_q[n], off);
        chk({tag, "_req_length"}, req_len_q[n], len);
      end
      off += len;
      n++;
    end
    chk({tag, "_req_count"}, req_idx_q.size(), n);
    chk({tag, "_word_count"}, out_w_q.size(), depth);
    m = (out_w_q.size() < int'(depth)) ? out_w_q.size() : int'(depth);
    for (int i = 0; i < m; i++) begin
      chk({tag, "_word"}, out_w_q[i], word_of(i));
      chk({tag, "_last"}, out_l_q[i], (i == int'(depth) - 1));
    end
    chk({tag, "_acc_pulses"}, acc_cnt, 1);
    chk({tag, "_hold_err"}, hold_err, 0);
    chk({tag, "_stab_err"}, stab_err, 0);
    chk({tag, "_ready_inv"}, inv_err, 0);
  endtask

  initial begin
    rst = 1'b0; conf_done = 1'b0; conf_info_depth = 32'd0;
    clear_logs();
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // Three bursts: 16, 16, 8
    run_load(32'd40, 0);
    check_load("d40", 32'd40);

    // Zero depth completes without any request
    clear_logs();
    conf_info_depth = 32'd0;
    conf_done = 1'b1;
    @(posedge clk); #1;
    chk("d0_acc_first", acc_done, 1);
    @(posedge clk); #1;
    chk("d0_acc_second", acc_done, 0);
    conf_done = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("d0_no_ctrl", ctrl_valid_cycles, 0);
    chk("d0_acc_pulses", acc_cnt, 1);

    // Backpressure on the output and a bursty channel
    out_pct = 50; chnl_pct = 70;
    run_load(32'd33, 0);
    check_load("d33_bp", 32'd33);

    // Request held off for five cycles
    out_pct = 100; chnl_pct = 100; ctrl_stall = 5;
    run_load(32'd10, 0);
    check_load("stall", 32'd10);
    chk("stall_valid_cycles", ctrl_valid_cycles, 6);

    // Reset in the middle of a burst, after beat 7
    clear_logs();
    salt = $urandom;
    conf_info_depth = 32'd16;
    conf_done = 1'b1;
    for (int i = 0; i < 200 && beats < 7; i++) begin
      @(posedge clk); #2;
    end
    chk("mid_beats", beats, 7);
    rst = 1'b0;
    conf_done = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_logs();
    repeat (5) @(posedge clk);
    #2;
    chk("midrst_no_restart", ctrl_valid_cycles, 0);
    run_load(32'd16, 0);
    check_load("restart", 32'd16);

    // conf_done held through completion: one pulse, no restart until it toggles
    run_load(32'd5, 20);
    check_load("held", 32'd5);
    run_load(32'd5, 0);
    check_load("retrig", 32'd5);

    // A few random depths with random flow control
    for (int k = 0; k < 3; k++) begin
      logic [31:0] d;
      d = $urandom_range(70, 1);
      out_pct = $urandom_range(90, 30);
      chnl_pct = $urandom_range(90, 30);
      run_load(d, 0);
      check_load("rand", d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
